// File: rtl/rv32i_ar_pkg.sv
// Shared constants and FSM state type for the RV32I register-file debug bridge.
package rv32i_ar_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  // Debug window onto the 32 integer registers; the base address is x0.
  localparam logic [15:0] AR_BASE = 16'h1000;
  localparam logic [15:0] AR_LAST = 16'h101F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } ar_state_e;

endpackage

// File: rtl/rv32i_ar_addr_chk.sv
// Combinational decode of a debug address against the register window.
module rv32i_ar_addr_chk
  import rv32i_ar_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] addr,
  output logic          in_win,
  output logic          x0_hit,
  output logic          out_win
);

  logic [31:0] a;

  // Zero-extend so the compare works for any AW up to 32.
  always_comb begin
    a       = 32'(addr);
    in_win  = (a >= 32'(AR_BASE)) && (a <= 32'(AR_LAST));
    x0_hit  = (a == 32'(AR_BASE));
    out_win = !in_win;
  end

endmodule

// File: rtl/rv32i_ar_bridge.sv
// Request/response bridge onto the register-file debug access port.
// Each beat is IDLE -> ACCESS (one cycle, AR_EN) -> RESP (held until taken).
// Optional feature: define RV32I_AR_BURST_EN for multi-beat reads driven by
// req_len; without it req_len is ignored and every response is the last one.
module rv32i_ar_bridge
  import rv32i_ar_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_ad,
  input  logic [DW-1:0] req_di,
  input  logic [7:0]    req_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_do,
  output logic          rsp_err,
  output logic          rsp_last,
  output logic          ar_en,
  output logic          ar_wr,
  output logic [AW-1:0] ar_ad,
  output logic [DW-1:0] ar_di,
  input  logic [DW-1:0] ar_do
);

  ar_state_e     state;
  logic          wr_q;
  logic [AW-1:0] ad_q;   // current beat address
  logic [DW-1:0] di_q;
  logic [7:0]    len_q;  // beats remaining after the current one

  logic in_win, x0_hit, out_win;
  logic len_bad, beat_err, beat_last, acc_en;

  rv32i_ar_addr_chk #(.AW(AW)) u_chk (
    .addr    (ad_q),
    .in_win  (in_win),
    .x0_hit  (x0_hit),
    .out_win (out_win)
  );

`ifdef RV32I_AR_BURST_EN
  // Bursting writes are not supported: flag them and skip the access.
  assign len_bad   = wr_q && (len_q != 8'd0);
  assign beat_last = out_win || len_bad || (len_q == 8'd0);
`else
  logic unused_len;
  assign unused_len = ^len_q;
  assign len_bad    = 1'b0;
  assign beat_last  = 1'b1;
`endif

  assign beat_err = out_win || len_bad;
  // x0 is hard-wired zero, so neither reads nor writes to it touch the port.
  assign acc_en   = (state == ST_ACCESS) && in_win && !x0_hit && !len_bad;

  assign ar_en     = acc_en;
  assign ar_wr     = acc_en && wr_q;
  assign ar_ad     = acc_en ? ad_q : '0;
  assign ar_di     = (acc_en && wr_q) ? di_q : '0;

  assign req_ready = (state == ST_IDLE) && rst_n;
  assign rsp_valid = (state == ST_RESP);

  // Beat sequencing, request capture and response registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_q     <= 1'b0;
      ad_q     <= '0;
      di_q     <= '0;
      len_q    <= '0;
      rsp_do   <= '0;
      rsp_err  <= 1'b0;
      rsp_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q  <= req_wr;
            ad_q  <= req_ad;
            di_q  <= req_di;
            len_q <= req_len;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rsp_do   <= (acc_en && !wr_q) ? ar_do : '0;
          rsp_err  <= beat_err;
          rsp_last <= beat_last;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (!rsp_last) begin
              ad_q  <= ad_q + AW'(1);
              len_q <= len_q - 8'd1;
              state <= ST_ACCESS;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_ar_bridge.sv
// Scoreboard bench for rv32i_ar_bridge; follows RV32I_AR_BURST_EN if defined.
module tb_rv32i_ar_bridge;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        l;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [15:0] req_ad = '0;
  logic [31:0] req_di = '0;
  logic [7:0]  req_len = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, rsp_last;
  logic [31:0] rsp_do;
  logic        ar_en, ar_wr;
  logic [15:0] ar_ad;
  logic [31:0] ar_di, ar_do;

  int   tests = 0, fails = 0, ar_cnt = 0;
  rsp_t sb[$];
  rsp_t me;
  logic [31:0] refm [32];
  logic [31:0] rf [32];
  logic rf_init = 1'b0;

  always #5 clk = ~clk;

  rv32i_ar_bridge #(.AW(16), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_ad(req_ad), .req_di(req_di), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_do(rsp_do),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .ar_en(ar_en), .ar_wr(ar_wr), .ar_ad(ar_ad), .ar_di(ar_di), .ar_do(ar_do)
  );

  function automatic logic [31:0] seed(input int i);
    return 32'hA500_0000 | (32'(i) * 32'h111);
  endfunction

  // Register file behind the debug port: combinational read, clocked write.
  assign ar_do = rf[ar_ad[4:0]];
  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= seed(i);
      rf_init <= 1'b1;
    end else if (ar_en && ar_wr) begin
      rf[ar_ad[4:0]] <= ar_di;
    end
  end

  // Count port accesses.
  always @(posedge clk) if (rst_n && ar_en) ar_cnt <= ar_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare each accepted response against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexp_rsp", 32'd1, 32'd0);
      else begin
        me = sb.pop_front();
        chk("rsp_do", rsp_do, me.d);
        chk("rsp_err", 32'(rsp_err), 32'(me.e));
        chk("rsp_last", 32'(rsp_last), 32'(me.l));
      end
    end
  end

  task automatic push_exp(input logic wr, input logic [15:0] ad, input logic [31:0] di,
                          input logic [7:0] len);
    rsp_t e;
    logic [15:0] a;
    int n;
    a = ad;
    n = 0;
`ifdef RV32I_AR_BURST_EN
    if (wr && len != 8'd0) begin
      e = '{32'h0, 1'b1, 1'b1};
      sb.push_back(e);
      return;
    end
    if (!wr) n = int'(len);
`else
    begin
      logic unused_l;
      unused_l = ^len;
    end
`endif
    for (int i = 0; i <= n; i++) begin
      if (a < 16'h1000 || a > 16'h101F) begin
        e = '{32'h0, 1'b1, 1'b1};
        sb.push_back(e);
        break;
      end
      e.d = (wr || a == 16'h1000) ? 32'h0 : refm[a[4:0]];
      e.e = 1'b0;
      e.l = (i == n);
      if (wr && a != 16'h1000) refm[a[4:0]] = di;
      sb.push_back(e);
      a++;
    end
  endtask

  // Queue the expectation, present the request, return just after acceptance.
  task automatic do_req(input logic wr, input logic [15:0] ad, input logic [31:0] di,
                        input logic [7:0] len);
    int b;
    push_exp(wr, ad, di, len);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_ad = ad; req_di = di; req_len = len;
    b = 0;
    while (!req_ready && b < 100) begin @(negedge clk); b++; end
    if (!req_ready) chk("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || !req_ready) && b < 100) begin @(negedge clk); b++; end
    chk("drain_done", 32'(sb.size() == 0 && req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 32; i++) refm[i] = seed(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ar_en", 32'(ar_en), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    rst_n = 1'b1;

    // Write then read 0x1005 with latency checks
    c0 = ar_cnt;
    do_req(1'b1, 16'h1005, 32'hDEADBEEF, 8'd0);
    @(negedge clk);
    chk("wr_ar_en", 32'(ar_en), 32'd1);
    chk("wr_ar_wr", 32'(ar_wr), 32'd1);
    chk("wr_ar_di", ar_di, 32'hDEADBEEF);
    drain();
    chk("wr_pulses", 32'(ar_cnt - c0), 32'd1);

    c0 = ar_cnt;
    do_req(1'b0, 16'h1005, 32'h0, 8'd0);
    @(negedge clk);
    chk("rd_ar_en_n1", 32'(ar_en), 32'd1);
    chk("rd_ar_ad", 32'(ar_ad), 32'h1005);
    chk("rd_no_valid_n1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd_valid_n2", 32'(rsp_valid), 32'd1);
    drain();
    chk("rd_pulses", 32'(ar_cnt - c0), 32'd1);

    // x0 accesses
    do_req(1'b1, 16'h1000, 32'h1234, 8'd0);
    do_req(1'b0, 16'h1000, 32'h0, 8'd0);
    drain();

    // Out-of-window read
    c0 = ar_cnt;
    do_req(1'b0, 16'h2003, 32'h0, 8'd0);
    drain();
    chk("oow_pulses", 32'(ar_cnt - c0), 32'd0);

    // Back-pressure on the response with a second request waiting
    rsp_ready = 1'b0;
    do_req(1'b0, 16'h1005, 32'h0, 8'd0);
    fork
      do_req(1'b1, 16'h1006, 32'h55AA, 8'd0);
      begin
        int c1;
        @(negedge clk);
        @(negedge clk);
        c1 = ar_cnt;
        repeat (5) begin
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_do", rsp_do, 32'hDEADBEEF);
          chk("hold_req_ready", 32'(req_ready), 32'd0);
          @(negedge clk);
        end
        chk("hold_no_access", 32'(ar_cnt - c1), 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_hs", 32'(req_ready), 32'd1);
      end
    join
    drain();

    // Burst read across the top of the window
    c0 = ar_cnt;
    do_req(1'b0, 16'h101E, 32'h0, 8'd3);
    drain();
`ifdef RV32I_AR_BURST_EN
    chk("burst_pulses", 32'(ar_cnt - c0), 32'd2);
`else
    chk("burst_pulses", 32'(ar_cnt - c0), 32'd1);
`endif

    // Write with nonzero length
    c0 = ar_cnt;
    do_req(1'b1, 16'h1003, 32'h0BAD_F00D, 8'd1);
    drain();
`ifdef RV32I_AR_BURST_EN
    chk("wrlen_pulses", 32'(ar_cnt - c0), 32'd0);
`else
    chk("wrlen_pulses", 32'(ar_cnt - c0), 32'd1);
`endif

    // Reset during ACCESS (second beat when bursting)
    do_req(1'b0, 16'h1002, 32'h0, 8'd3);
    @(negedge clk);
`ifdef RV32I_AR_BURST_EN
    @(negedge clk);
    @(negedge clk);
`endif
    chk("pre_rst_ar_en", 32'(ar_en), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rsp_do", rsp_do, 32'd0);
    chk("mrst_rsp_err", 32'(rsp_err), 32'd0);
    chk("mrst_rsp_last", 32'(rsp_last), 32'd0);
    chk("mrst_ar_en", 32'(ar_en), 32'd0);
    chk("mrst_ar_wr", 32'(ar_wr), 32'd0);
    chk("mrst_ar_ad", 32'(ar_ad), 32'd0);
    chk("mrst_ar_di", ar_di, 32'd0);
    chk("mrst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'(rsp_valid), 32'd0);

    c0 = ar_cnt;
    do_req(1'b0, 16'h1005, 32'h0, 8'd0);
    drain();
    chk("post_rst_pulses", 32'(ar_cnt - c0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32i_ar_bridge.md
RV32I_AR_BRIDGE -- requirements
Module: rv32i_ar_bridge

Interface
REQ-001 Parameter AW, default 16, is the AR address width.
REQ-002 Parameter DW, default 32, is the data width.
REQ-003 CLK  in  1  is the single clock; all state changes on its rising edge.
REQ-004 RST_N  in  1  is the asynchronous, active-low reset.
REQ-005 REQ_VALID in 1 and REQ_READY out 1 form the request handshake.
REQ-006 REQ_WR in 1 selects write (1) or read (0); REQ_AD in AW is the address; REQ_DI in DW is the write data.
REQ-007 REQ_LEN in 8 is the read burst beat count minus 1.
REQ-008 RSP_VALID out 1 and RSP_READY in 1 form the response handshake.
REQ-009 RSP_DO out DW, RSP_ERR out 1 and RSP_LAST out 1 are the response payload.
REQ-010 AR_EN out 1, AR_WR out 1, AR_AD out AW, AR_DI out DW and AR_DO in DW connect to the register-file debug access port.

Function
REQ-011 FSM states are IDLE, ACCESS and RESP.
- REQ_READY = (state==IDLE), and is 0 while RST_N is low.
REQ-012 IDLE: on REQ_VALID&&REQ_READY, capture WR, AD, DI and LEN, and go to ACCESS.
REQ-013 ACCESS lasts exactly one cycle, then goes to RESP.
- AR_EN=1 with AR_WR/AR_AD/AR_DI driven from the captured registers.
- AR_EN=0 in all other states.
REQ-014 Read capture: in ACCESS the block registers AR_DO into RSP_DO (same-cycle combinational read).
- Write: RSP_DO=0.
REQ-015 RESP: RSP_VALID=1 and the payload is held stable until RSP_READY=1.
- On RSP_READY=1, go to IDLE (or to the next beat, per REQ-022).
REQ-016 Latency: request accepted at edge N -> AR_EN high in cycle N+1 -> RSP_VALID high from cycle N+2.
- Minimum 3 cycles per single transaction.
REQ-017 Valid address window is 0x1000..0x101F.
- 0x1000 (x0) reads return 0; writes to 0x1000 are ignored.
- Both complete with RSP_ERR=0.
REQ-018 An out-of-window address produces no AR_EN pulse.
- The FSM still passes through ACCESS; response is RSP_ERR=1, RSP_DO=0.
REQ-019 RSP_VALID is never asserted without a prior accepted request.
- A new request is never accepted while RSP_VALID=1.

Reset
REQ-020 RST_N low immediately forces:
- state to IDLE;
- RSP_VALID, RSP_DO, RSP_ERR, RSP_LAST, AR_EN, AR_WR, AR_AD and AR_DI to 0;
- the beat counter to 0.
- An in-flight transaction, including one mid-burst, is discarded with no response.
REQ-021 The first request is accepted no earlier than the first rising edge after RST_N deasserts.

Configuration
REQ-022 With RV32I_AR_BURST_EN defined, a read with REQ_LEN=L issues L+1 beats.
- Each beat is ACCESS then RESP; after each handshake the address increments by 1.
- RSP_LAST=1 only on the final beat.
- A beat whose address leaves the window returns RSP_ERR=1 with RSP_LAST=1, and the burst terminates.
- A write with REQ_LEN!=0 performs no access and returns RSP_ERR=1, RSP_LAST=1.
REQ-023 Without RV32I_AR_BURST_EN, the REQ_LEN port remains present but is ignored.
- Every transaction is one beat and RSP_LAST is constant 1.

Structure
REQ-024 Package rv32i_ar_pkg holds:
- the FSM state enum;
- AR base 16'h1000, last valid address 16'h101F, and AW/DW defaults.
REQ-025 Sub-module rv32i_ar_addr_chk (combinational) decodes in-window, x0-hit and out-of-window from an address.
- It is instantiated once, on the current beat address.

Verification
REQ-026 Write 0x1005 <- 0xDEADBEEF, then read 0x1005.
- Expected: exactly one AR_EN/AR_WR pulse, then a response with RSP_DO=0xDEADBEEF, ERR=0, LAST=1, RSP_VALID at N+2.
REQ-027 Read 0x1000 and write 0x1000 <- 0x1234.
- Expected: both complete with ERR=0, and the read returns 0.
REQ-028 Read 0x2003.
- Expected: no AR_EN pulse; response RSP_ERR=1, RSP_DO=0.
REQ-029 Hold RSP_READY=0 for 5 cycles during RESP while REQ_VALID=1.
- Expected: payload stable, REQ_READY=0 and no second AR_EN; one cycle after the handshake, REQ_READY=1.
REQ-030 (BURST_EN) Read 0x101E with LEN=3.
- Expected: beats at 0x101E and 0x101F with ERR=0, LAST=0; third beat ERR=1, LAST=1; no fourth beat.
REQ-031 Assert RST_N low in ACCESS mid-burst.
- Expected: all outputs 0 immediately, no response after release, and the next request completes normally.
